// File: rtl/pwls_sample_out_if.sv
// pwls_sample_out_if: sample stream in, PWM audio status out.
// master drives samples, slave is the PWM output stage.
interface pwls_sample_out_if #(
  parameter int BITS     = 12,
  parameter int OUT_BITS = 8
);
  logic                sample_valid;
  logic [BITS-1:0]     sample;
  logic                clear_overrun;
  logic                pwm_out;
  logic                period_start;
  logic [OUT_BITS-1:0] active_level;
  logic                overrun;

  modport master (
    output sample_valid,
    output sample,
    output clear_overrun,
    input  pwm_out,
    input  period_start,
    input  active_level,
    input  overrun
  );

  modport slave (
    input  sample_valid,
    input  sample,
    input  clear_overrun,
    output pwm_out,
    output period_start,
    output active_level,
    output overrun
  );
endinterface

// File: rtl/pwls_sample_out.sv
// pwls_sample_out: double-buffered signed sample to single-bit PWM.
// Define PWLS_SAMPLE_OUT_NOISE_SHAPE_EN for first-order noise shaping.
module pwls_sample_out #(
  parameter int BITS     = 12,
  parameter int OUT_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pwls_sample_out_if.slave bus
);
  localparam int EW = BITS - OUT_BITS;
  localparam logic [OUT_BITS-1:0] MID =
    {1'b1, {(OUT_BITS-1){1'b0}}};

  logic [OUT_BITS-1:0] cnt;
  logic [OUT_BITS-1:0] active;
  logic [OUT_BITS-1:0] active_nxt;
  logic [BITS-1:0]     pending;
  logic [BITS-1:0]     u;
  logic [BITS-1:0]     u_sel;
  logic                pending_full;
  logic                overrun_q;
  logic                pwm_q;
  logic                xfer;
  logic                load;
  logic                lost;

  assign u     = {~bus.sample[BITS-1], bus.sample[BITS-2:0]};
  assign xfer  = &cnt;
  assign load  = xfer & (bus.sample_valid | pending_full);
  assign lost  = bus.sample_valid & pending_full;
  // A strobe on the transfer cycle bypasses the buffer.
  assign u_sel = bus.sample_valid ? u : pending;

`ifdef PWLS_SAMPLE_OUT_NOISE_SHAPE_EN
  logic [EW-1:0] err;
  logic [EW-1:0] err_nxt;
  logic [BITS:0] s;

  always_comb begin
    s = {1'b0, u_sel} + {{(OUT_BITS+1){1'b0}}, err};
    if (s[BITS]) begin
      active_nxt = '1;
      err_nxt    = '0;
    end else begin
      active_nxt = s[BITS-1 -: OUT_BITS];
      err_nxt    = s[EW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= '0;
    end else if (load) begin
      err <= err_nxt;
    end
  end
`else
  logic unused_low;

  assign active_nxt = u_sel[BITS-1 -: OUT_BITS];
  assign unused_low = ^u_sel[EW-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      overrun_q    <= 1'b0;
      pwm_q        <= 1'b0;
      active       <= MID;
    end else begin
      cnt   <= cnt + 1'b1;
      pwm_q <= cnt < active;
      if (xfer) begin
        pending_full <= 1'b0;
      end else if (bus.sample_valid) begin
        pending      <= u;
        pending_full <= 1'b1;
      end
      if (load) begin
        active <= active_nxt;
      end
      // Set wins over a coincident clear.
      if (lost) begin
        overrun_q <= 1'b1;
      end else if (bus.clear_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = cnt == '0;
  assign bus.active_level = active;
  assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_pwls_sample_out.sv
// tb_pwls_sample_out: directed bench for the PWM output stage.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pwls_sample_out;
  localparam int BITS     = 12;
  localparam int OUT_BITS = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   h;

  pwls_sample_out_if #(.BITS(BITS), .OUT_BITS(OUT_BITS)) bus ();

  pwls_sample_out #(.BITS(BITS), .OUT_BITS(OUT_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync();
    int k = 0;
    while (bus.period_start !== 1'b1 && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("sync", {31'b0, bus.period_start}, 32'd1);
  endtask

  task automatic strobe(input logic [11:0] v);
    bus.sample       = v;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic count_high(output int n);
    n = 0;
    @(negedge clk);
    repeat (256) begin
      if (bus.pwm_out === 1'b1) n++;
      @(negedge clk);
    end
  endtask

  initial begin
    bus.sample_valid  = 1'b0;
    bus.sample        = '0;
    bus.clear_overrun = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_pwm", {31'b0, bus.pwm_out}, 32'd0);
    check("rst_active", {24'b0, bus.active_level}, 32'h80);
    check("rst_overrun", {31'b0, bus.overrun}, 32'd0);
    check("rst_pstart", {31'b0, bus.period_start}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    sync();
    strobe(12'h000);
    sync();
    check("mid_active", {24'b0, bus.active_level}, 32'h80);
    check("mid_overrun", {31'b0, bus.overrun}, 32'd0);
    count_high(h);
    check("mid_high", h, 32'd128);

    sync();
    strobe(12'h7FF);
    sync();
    check("max_active", {24'b0, bus.active_level}, 32'hFF);
    count_high(h);
    check("max_high", h, 32'd255);

    sync();
    strobe(12'h800);
    sync();
    check("min_active", {24'b0, bus.active_level}, 32'h00);
    count_high(h);
    check("min_high", h, 32'd0);

    sync();
    strobe(12'h100);
    tick(3);
    strobe(12'h200);
    check("ovr_set", {31'b0, bus.overrun}, 32'd1);
    sync();
    check("ovr_newest", {24'b0, bus.active_level}, 32'hA0);
    bus.clear_overrun = 1'b1;
    tick(1);
    bus.clear_overrun = 1'b0;
    check("ovr_clear", {31'b0, bus.overrun}, 32'd0);
    sync();
    strobe(12'h100);
    tick(2);
    bus.clear_overrun = 1'b1;
    strobe(12'h300);
    bus.clear_overrun = 1'b0;
    check("ovr_set_wins", {31'b0, bus.overrun}, 32'd1);
    sync();
    check("ovr_active", {24'b0, bus.active_level}, 32'hB0);
    bus.clear_overrun = 1'b1;
    tick(1);
    bus.clear_overrun = 1'b0;
    check("ovr_clear2", {31'b0, bus.overrun}, 32'd0);

    sync();
    strobe(12'h100);
    tick(254);
    check("byp_cnt255", {31'b0, bus.period_start}, 32'd0);
    strobe(12'h400);
    check("byp_pstart", {31'b0, bus.period_start}, 32'd1);
    check("byp_active", {24'b0, bus.active_level}, 32'hC0);
    check("byp_overrun", {31'b0, bus.overrun}, 32'd1);
    bus.clear_overrun = 1'b1;
    tick(1);
    bus.clear_overrun = 1'b0;
    count_high(h);
    check("byp_high", h, 32'd192);
    tick(3 * 256);
    check("hold_active", {24'b0, bus.active_level}, 32'hC0);
    check("hold_overrun", {31'b0, bus.overrun}, 32'd0);

    sync();
    tick(100);
    check("pre_rst_pwm", {31'b0, bus.pwm_out}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_pwm", {31'b0, bus.pwm_out}, 32'd0);
    check("mrst_active", {24'b0, bus.active_level}, 32'h80);
    check("mrst_pstart", {31'b0, bus.period_start}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    count_high(h);
    check("mrst_high", h, 32'd128);

    for (int i = 0; i < 4; i++) begin
      sync();
      strobe(12'h008);
      sync();
`ifdef PWLS_SAMPLE_OUT_NOISE_SHAPE_EN
      check("ns_active", {24'b0, bus.active_level},
            (i % 2 == 0) ? 32'h80 : 32'h81);
`else
      check("tr_active", {24'b0, bus.active_level}, 32'h80);
`endif
    end

    for (int i = 0; i < 3; i++) begin
      sync();
      strobe(12'h7FF);
      sync();
      check("sat_active", {24'b0, bus.active_level}, 32'hFF);
    end
    count_high(h);
    check("sat_high", h, 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
